// File: rtl/reg_port_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_port_pkg
// Brief   : Shared widths, FSM state encoding and write-FIFO entry type.
// Revision: 1.0 - initial release
// ============================================================================
package reg_port_pkg;

    localparam int REG_AW = 3;
    localparam int REG_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wr_entry_t;

endpackage
`default_nettype wire

// File: rtl/wr_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wr_fifo
// Brief   : Circular write-back buffer; exposes entries oldest-first for compare.
// Revision: 1.0 - initial release
// ============================================================================
module wr_fifo
    import reg_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wr_entry_t               push_entry,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output wr_entry_t [DEPTH-1:0]   ordered,
    output logic      [DEPTH-1:0]   ordered_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wr_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Slot k holds the k-th oldest entry, so index 0 is the head.
    for (genvar k = 0; k < DEPTH; k++) begin : g_order
        assign ordered[k]       = mem[rd_ptr + PW'(k)];
        assign ordered_valid[k] = (count > CW'(k));
    end

endmodule
`default_nettype wire

// File: rtl/reg_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : reg_port_ctrl
// Brief   : Shared-port RF arbiter: buffered writes vs dual-operand reads.
//           Optional macro REGPORT_FWD_EN forwards queued data to reads.
// Revision: 1.0 - initial release
// ============================================================================
module reg_port_ctrl
    import reg_port_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [REG_DW-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic              rsp_valid,
    output logic [REG_DW-1:0] rsp_data1,
    output logic [REG_DW-1:0] rsp_data2,
    output logic [REG_AW-1:0] rf_op1,
    output logic [REG_AW-1:0] rf_op2,
    output logic [REG_DW-1:0] rf_data,
    output logic              rf_en_write,
    input  logic [REG_DW-1:0] rf_out1,
    input  logic [REG_DW-1:0] rf_out2
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    state_t                state;
    logic                  active;
    logic [SW-1:0]         starve;
    logic [REG_AW-1:0]     last_wr_addr;
    logic [REG_AW-1:0]     op1_q;
    logic [REG_AW-1:0]     op2_q;
    logic [REG_DW-1:0]     data_q;

    logic                  push;
    logic                  full;
    logic                  empty;
    wr_entry_t [DEPTH-1:0] ordered;
    logic      [DEPTH-1:0] ordered_valid;
    wr_entry_t             head;

    logic                  hit1;
    logic                  hit2;
    logic                  rd_req;
    logic                  grant_ok;
    logic                  do_write;
    logic                  do_read;
    logic [REG_DW-1:0]     sel1;
    logic [REG_DW-1:0]     sel2;

    assign wr_ready = active & ~full;
    assign push     = wr_valid & wr_ready;
    assign head     = ordered[0];

    wr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_entry   ({wr_addr, wr_data}),
        .pop          (do_write),
        .full         (full),
        .empty        (empty),
        .ordered      (ordered),
        .ordered_valid(ordered_valid)
    );

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ordered_valid[k] && (ordered[k].addr == rd_addr1)) hit1 = 1'b1;
            if (ordered_valid[k] && (ordered[k].addr == rd_addr2)) hit2 = 1'b1;
        end
    end

`ifdef REGPORT_FWD_EN
    logic [REG_DW-1:0] fwd1;
    logic [REG_DW-1:0] fwd2;

    // Scanning oldest to youngest lets the youngest match win.
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ordered_valid[k] && (ordered[k].addr == rd_addr1)) fwd1 = ordered[k].data;
            if (ordered_valid[k] && (ordered[k].addr == rd_addr2)) fwd2 = ordered[k].data;
        end
    end

    assign rd_req = rd_valid;
    assign sel1   = hit1 ? fwd1 : rf_out1;
    assign sel2   = hit2 ? fwd2 : rf_out2;
`else
    logic unused_fifo_data;

    assign unused_fifo_data = ^ordered;
    // A hazard-blocked read looks like no read, so the queue drains.
    assign rd_req = rd_valid & ~(hit1 | hit2);
    assign sel1   = rf_out1;
    assign sel2   = rf_out2;
`endif

    assign grant_ok = active && (state != RECOVER);
    assign do_write = grant_ok && !empty &&
                      (full || (starve == SW'(STARVE_LIMIT)) || !rd_req);
    assign do_read  = grant_ok && !do_write && rd_req;
    assign rd_ready = do_read;

    always_comb begin
        rf_en_write = do_write;
        rf_op1      = op1_q;
        rf_op2      = op2_q;
        rf_data     = data_q;
        if (do_write) begin
            rf_op1  = head.addr;
            rf_data = head.data;
        end else if (do_read) begin
            rf_op1 = rd_addr1;
            rf_op2 = rd_addr2;
        end else if (state == RECOVER) begin
            // Moving both op lines off the written address makes the RF re-evaluate.
            rf_op1 = ~last_wr_addr;
            rf_op2 = ~last_wr_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            active       <= 1'b0;
            starve       <= '0;
            last_wr_addr <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            data_q       <= '0;
            rsp_valid    <= 1'b0;
            rsp_data1    <= '0;
            rsp_data2    <= '0;
        end else begin
            active    <= 1'b1;
            op1_q     <= rf_op1;
            op2_q     <= rf_op2;
            data_q    <= rf_data;
            rsp_valid <= do_read;
            if (do_write) begin
                state        <= RECOVER;
                last_wr_addr <= head.addr;
                starve       <= '0;
            end else if (do_read) begin
                state     <= READ;
                rsp_data1 <= sel1;
                rsp_data2 <= sel2;
                if (!empty && (starve != SW'(STARVE_LIMIT))) starve <= starve + 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
`default_nettype wire
